// File: rtl/uart_rx_deserializer.sv
// UART receive front end: synchronises the serial line, qualifies the start bit at
// mid-bit, shifts data in LSB-first and presents the completed word on dout1. It
// also frames the second half of the stop bit with checkstop for the stop-bit checker.
//
// Ports
//   clk         system clock, all flops on posedge
//   reset       asynchronous, active-low reset
//   baudtick    one-clk enable at OVERSAMPLE x baud rate; gates all counting
//   rxin        raw serial line, idle high, asynchronous to clk
//   dout1       last complete received word
//   checkstop   high while the stop-bit window is being checked
//   rxbusy      high whenever a frame is in progress
//   rxdone      one-clk pulse when a frame completes
//   starterror  one-clk pulse when a false start is rejected
module uart_rx_deserializer #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baudtick,
  input  logic                 rxin,
  output logic [DATA_BITS-1:0] dout1,
  output logic                 checkstop,
  output logic                 rxbusy,
  output logic                 rxdone,
  output logic                 starterror
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

  localparam logic [TickW-1:0] TickHalfLast = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickFullLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast      = BitW'(DATA_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStopW, StStop} state_e;

  state_e               state_q, state_d;
  logic [TickW-1:0]     tickcnt_q, tickcnt_d;
  logic [BitW-1:0]      bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, shreg_shifted;
  logic [DATA_BITS-1:0] dout1_q, dout1_d;
  logic                 checkstop_q, checkstop_d;
  logic                 rxdone_q, rxdone_d;
  logic                 starterror_q, starterror_d;
  logic                 rx_meta_q, rxs_q;

  // Two-flop synchroniser; flops reset to the idle line level so reset never
  // looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rxin;
      rxs_q     <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      tickcnt_q    <= '0;
      bitcnt_q     <= '0;
      shreg_q      <= '0;
      dout1_q      <= '0;
      checkstop_q  <= 1'b0;
      rxdone_q     <= 1'b0;
      starterror_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tickcnt_q    <= tickcnt_d;
      bitcnt_q     <= bitcnt_d;
      shreg_q      <= shreg_d;
      dout1_q      <= dout1_d;
      checkstop_q  <= checkstop_d;
      rxdone_q     <= rxdone_d;
      starterror_q <= starterror_d;
    end
  end

  assign shreg_shifted = {rxs_q, shreg_q[DATA_BITS-1:1]};

  always_comb begin
    state_d      = state_q;
    tickcnt_d    = tickcnt_q;
    bitcnt_d     = bitcnt_q;
    shreg_d      = shreg_q;
    dout1_d      = dout1_q;
    checkstop_d  = checkstop_q;
    rxdone_d     = 1'b0;
    starterror_d = 1'b0;

    if (baudtick) begin
      unique case (state_q)
        StIdle: begin
          if (!rxs_q) begin
            state_d   = StStart;
            tickcnt_d = '0;
          end
        end
        StStart: begin
          if (tickcnt_q == TickHalfLast) begin
            tickcnt_d = '0;
            if (!rxs_q) begin
              state_d  = StData;
              bitcnt_d = '0;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state_d      = StIdle;
              starterror_d = 1'b1;
            end
          end else begin
            tickcnt_d = tickcnt_q + TickW'(1);
          end
        end
        StData: begin
          if (tickcnt_q == TickFullLast) begin
            shreg_d   = shreg_shifted;
            tickcnt_d = '0;
            bitcnt_d  = bitcnt_q + BitW'(1);
            if (bitcnt_q == BitLast) begin
              dout1_d = shreg_shifted;
              state_d = StStopW;
            end
          end else begin
            tickcnt_d = tickcnt_q + TickW'(1);
          end
        end
        StStopW: begin
          if (tickcnt_q == TickFullLast) begin
            state_d     = StStop;
            tickcnt_d   = '0;
            checkstop_d = 1'b1;
          end else begin
            tickcnt_d = tickcnt_q + TickW'(1);
          end
        end
        StStop: begin
          if (tickcnt_q == TickHalfLast) begin
            state_d     = StIdle;
            tickcnt_d   = '0;
            checkstop_d = 1'b0;
            rxdone_d    = 1'b1;
          end else begin
            tickcnt_d = tickcnt_q + TickW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign dout1      = dout1_q;
  assign checkstop  = checkstop_q;
  assign rxbusy     = (state_q != StIdle);
  assign rxdone     = rxdone_q;
  assign starterror = starterror_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: directed frames, glitches, reset
// abort and randomised frames at several baudtick rates, checked against a queue of
// expected words and pulse counts.
module tb_uart_rx_deserializer;

  localparam int unsigned DataBits = 8;
  localparam int unsigned Os       = 16;
  localparam int unsigned Half     = Os / 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                baudtick;
  logic                rxin;
  logic [DataBits-1:0] dout1;
  logic                checkstop;
  logic                rxbusy;
  logic                rxdone;
  logic                starterror;

  int unsigned div = 1;
  int unsigned div_cnt = 0;
  int n_cmp = 0;
  int n_err = 0;
  int done_count = 0;
  int frames_sent = 0;
  int se_count = 0;
  int se_exp = 0;
  int unsigned cs_ticks = 0;
  int unsigned cs_clks = 0;
  bit cs_saw_low = 1'b0;
  logic [DataBits-1:0] exp_q[$];
  logic [DataBits-1:0] last_word = '0;

  uart_rx_deserializer #(
    .DATA_BITS (DataBits),
    .OVERSAMPLE(Os)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .baudtick  (baudtick),
    .rxin      (rxin),
    .dout1     (dout1),
    .checkstop (checkstop),
    .rxbusy    (rxbusy),
    .rxdone    (rxdone),
    .starterror(starterror)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Baudtick generator: one pulse every 'div' clocks, updated just after posedge.
  initial begin
    baudtick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (div_cnt + 1 >= div) begin
        baudtick = 1'b1;
        div_cnt  = 0;
      end else begin
        baudtick = 1'b0;
        div_cnt++;
      end
    end
  end

  // Output monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        cs_ticks = 0;
        cs_clks  = 0;
      end else begin
        if (rxdone) begin
          done_count++;
          check_eq("rxdone_pending", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check_eq("dout1_word", dout1, exp_q.pop_front());
        end
        if (starterror) se_count++;
        if (checkstop && !rxin) cs_saw_low = 1'b1;
        if (checkstop) begin
          cs_clks++;
          if (baudtick) cs_ticks++;
        end else if (cs_clks != 0) begin
          check_eq("checkstop_ticks", cs_ticks, Half);
          check_eq("checkstop_clks", cs_clks, Half * div);
          cs_ticks = 0;
          cs_clks  = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!baudtick) @(posedge clk);
    end
  endtask

  task automatic drive_bit(input logic b);
    rxin = b;
    wait_ticks(Os);
    #1;
  endtask

  task automatic idle_ticks(input int n);
    rxin = 1'b1;
    wait_ticks(n);
    #1;
  endtask

  task automatic set_div(input int unsigned d);
    @(negedge clk);
    div = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DataBits-1:0] data, input logic stop_bit);
    exp_q.push_back(data);
    last_word = data;
    frames_sent++;
    drive_bit(1'b0);
    check_eq("rxbusy_in_frame", rxbusy, 1);
    for (int i = 0; i < DataBits; i++) drive_bit(data[i]);
    drive_bit(stop_bit);
  endtask

  task automatic glitch(input int g);
    se_exp++;
    rxin = 1'b0;
    wait_ticks(g);
    #1;
    idle_ticks(2 * Os);
    check_eq("starterror_count", se_count, se_exp);
    check_eq("rxbusy_after_glitch", rxbusy, 0);
    check_eq("dout1_kept_after_glitch", dout1, last_word);
  endtask

  task automatic check_settled(input string tag);
    check_eq({tag, "_rxdone_count"}, done_count, frames_sent);
    check_eq({tag, "_starterror_count"}, se_count, se_exp);
    check_eq({tag, "_rxbusy_idle"}, rxbusy, 0);
  endtask

  initial begin
    logic [DataBits-1:0] word;
    reset = 1'b0;
    rxin  = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_dout1", dout1, 0);
    check_eq("reset_checkstop", checkstop, 0);
    check_eq("reset_rxbusy", rxbusy, 0);
    check_eq("reset_rxdone", rxdone, 0);
    check_eq("reset_starterror", starterror, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_ticks(Os);

    // Single frame, baudtick every clock.
    send_frame(8'hA5, 1'b1);
    idle_ticks(Os);
    check_settled("a5");
    check_eq("dout1_a5_held", dout1, 8'hA5);

    // Short low pulse is rejected as a false start.
    glitch(4);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle_ticks(Os);
    check_settled("b2b");

    // Low stop bit still completes the frame.
    cs_saw_low = 1'b0;
    send_frame(8'h3C, 1'b0);
    idle_ticks(Os);
    check_settled("lowstop");
    check_eq("checkstop_with_low_stop", cs_saw_low, 1);

    // Reset in the middle of data bit 4 aborts the frame.
    word = 8'h81;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(word[i]);
    rxin = word[4];
    wait_ticks(Half);
    #1;
    check_eq("rxbusy_before_reset", rxbusy, 1);
    reset = 1'b0;
    #1;
    check_eq("midreset_dout1", dout1, 0);
    check_eq("midreset_checkstop", checkstop, 0);
    check_eq("midreset_rxbusy", rxbusy, 0);
    check_eq("midreset_rxdone", rxdone, 0);
    check_eq("midreset_starterror", starterror, 0);
    rxin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    idle_ticks(2 * Os);
    send_frame(8'h81, 1'b1);
    idle_ticks(Os);
    check_settled("after_reset");

    // Same word at two baudtick rates.
    send_frame(8'h5A, 1'b1);
    idle_ticks(Os);
    set_div(7);
    send_frame(8'h5A, 1'b1);
    idle_ticks(Os);
    check_settled("div7");

    // Randomised frames, rates and glitches.
    for (int n = 0; n < 16; n++) begin
      set_div($urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) glitch($urandom_range(1, 4));
      send_frame(DataBits'($urandom), 1'b1);
      idle_ticks($urandom_range(1, 3) * Os);
      check_settled("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
